// File: rtl/axi_10g_ethernet_0_fifo_wr_ctrl.sv
// rtl/axi_10g_ethernet_0_fifo_wr_ctrl.sv - write-side controller for the 10G receive packet FIFO
module axi_10g_ethernet_0_fifo_wr_ctrl #(
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  wr_clk,
    input  logic                  wr_sreset,
    input  logic [63:0]           rx_axis_tdata,
    input  logic [7:0]            rx_axis_tkeep,
    input  logic                  rx_axis_tvalid,
    input  logic                  rx_axis_tlast,
    input  logic                  rx_axis_tuser,
    input  logic [ADDR_WIDTH-1:0] rd_addr_sync,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [67:0]           wr_data,
    output logic                  wr_allow,
    output logic [ADDR_WIDTH-1:0] wr_commit_addr,
    output logic                  wr_commit_toggle,
    output logic                  fifo_full,
    output logic [15:0]           frames_dropped,
    output logic                  overflow_pulse
);

    typedef enum logic [1:0] {IDLE, WRITE, DROP} state_t;

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   ptr, ptr_nxt, ptr_inc;
    logic [ADDR_WIDTH-1:0]   commit, commit_nxt;
    logic                    full;
    logic                    do_write, do_commit, do_drop, do_ovf;

    // Valid byte count mod 8; tkeep is contiguous so a popcount is exact.
    function automatic logic [2:0] keep_code(input logic [7:0] k);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, k[i]};
        end
        return n[2:0];
    endfunction

    assign ptr_inc        = ptr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    assign full           = (ptr_inc == rd_addr_sync);
    assign wr_commit_addr = commit;

    // Next-state: accept, roll back or discard each incoming beat.
    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        commit_nxt = commit;
        do_write   = 1'b0;
        do_commit  = 1'b0;
        do_drop    = 1'b0;
        do_ovf     = 1'b0;
        case (state)
            IDLE, WRITE: begin
                if (rx_axis_tvalid) begin
                    if (!full) begin
                        do_write = 1'b1;
                        ptr_nxt  = ptr_inc;
                        if (!rx_axis_tlast) begin
                            state_nxt = WRITE;
                        end else if (rx_axis_tuser) begin
                            commit_nxt = ptr_inc;
                            do_commit  = 1'b1;
                            state_nxt  = IDLE;
                        end else begin
                            // Bad frame: last word lands in RAM but is never published.
                            ptr_nxt   = commit;
                            do_drop   = 1'b1;
                            state_nxt = IDLE;
                        end
                    end else begin
                        ptr_nxt   = commit;
                        do_ovf    = 1'b1;
                        do_drop   = 1'b1;
                        state_nxt = rx_axis_tlast ? IDLE : DROP;
                    end
                end
            end
            DROP: begin
                if (rx_axis_tvalid && rx_axis_tlast) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, pointers and registered RAM write port / status outputs.
    always_ff @(posedge wr_clk) begin
        if (wr_sreset) begin
            state            <= IDLE;
            ptr              <= '0;
            commit           <= '0;
            wr_allow         <= 1'b0;
            wr_addr          <= '0;
            wr_data          <= '0;
            wr_commit_toggle <= 1'b0;
            fifo_full        <= 1'b0;
            frames_dropped   <= 16'd0;
            overflow_pulse   <= 1'b0;
        end else begin
            state            <= state_nxt;
            ptr              <= ptr_nxt;
            commit           <= commit_nxt;
            wr_allow         <= do_write;
            if (do_write) begin
                wr_addr <= ptr;
                wr_data <= {rx_axis_tlast, keep_code(rx_axis_tkeep), rx_axis_tdata};
            end
            wr_commit_toggle <= wr_commit_toggle ^ do_commit;
            fifo_full        <= full;
            if (do_drop) begin
                frames_dropped <= frames_dropped + 16'd1;
            end
            overflow_pulse   <= do_ovf;
        end
    end

endmodule

// File: tb/tb_axi_10g_ethernet_0_fifo_wr_ctrl.sv
// tb/tb_axi_10g_ethernet_0_fifo_wr_ctrl.sv - self-checking bench for the receive FIFO write controller
module tb_axi_10g_ethernet_0_fifo_wr_ctrl;

    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

    logic          wr_clk = 1'b0;
    logic          wr_sreset;
    logic [63:0]   rx_axis_tdata;
    logic [7:0]    rx_axis_tkeep;
    logic          rx_axis_tvalid;
    logic          rx_axis_tlast;
    logic          rx_axis_tuser;
    logic [AW-1:0] rd_addr_sync;
    logic [AW-1:0] wr_addr;
    logic [67:0]   wr_data;
    logic          wr_allow;
    logic [AW-1:0] wr_commit_addr;
    logic          wr_commit_toggle;
    logic          fifo_full;
    logic [15:0]   frames_dropped;
    logic          overflow_pulse;

    axi_10g_ethernet_0_fifo_wr_ctrl #(.ADDR_WIDTH(AW)) dut (
        .wr_clk          (wr_clk),
        .wr_sreset       (wr_sreset),
        .rx_axis_tdata   (rx_axis_tdata),
        .rx_axis_tkeep   (rx_axis_tkeep),
        .rx_axis_tvalid  (rx_axis_tvalid),
        .rx_axis_tlast   (rx_axis_tlast),
        .rx_axis_tuser   (rx_axis_tuser),
        .rd_addr_sync    (rd_addr_sync),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .wr_allow        (wr_allow),
        .wr_commit_addr  (wr_commit_addr),
        .wr_commit_toggle(wr_commit_toggle),
        .fifo_full       (fifo_full),
        .frames_dropped  (frames_dropped),
        .overflow_pulse  (overflow_pulse)
    );

    always #5 wr_clk = ~wr_clk;

    int checks = 0;
    int errors = 0;
    int n_writes = 0;

    // Reference model: where the frame stands, in plain integers.
    int m_ptr, m_commit, m_dropped;
    bit m_toggle, m_dropping;

    typedef struct {
        logic [7:0] keep;
        logic [2:0] code;
    } kv_t;
    kv_t kv [8];

    task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_commit = 0; m_dropped = 0; m_toggle = 0; m_dropping = 0;
    endtask

    // One clock: drive a beat (or idle), then compare all outputs with the model.
    task automatic step(input bit v, input logic [63:0] d, input logic [7:0] k,
                        input bit l, input bit u);
        bit        e_wr, e_ovf, e_full;
        int        e_addr;
        logic [67:0] e_data;
        e_wr = 0; e_ovf = 0; e_addr = 0; e_data = '0;
        @(negedge wr_clk);
        rx_axis_tvalid = v; rx_axis_tdata = d; rx_axis_tkeep = k;
        rx_axis_tlast = l; rx_axis_tuser = u;
        e_full = (((m_ptr + 1) % DEPTH) == int'(rd_addr_sync));
        if (v) begin
            if (m_dropping) begin
                if (l) m_dropping = 0;
            end else if (e_full) begin
                e_ovf = 1; m_ptr = m_commit; m_dropped++; m_dropping = !l;
            end else begin
                e_wr = 1; e_addr = m_ptr;
                e_data = {l, 3'($countones(k) % 8), d};
                m_ptr = (m_ptr + 1) % DEPTH;
                if (l) begin
                    if (u) begin m_commit = m_ptr; m_toggle = !m_toggle; end
                    else begin m_ptr = m_commit; m_dropped++; end
                end
            end
        end
        @(posedge wr_clk);
        #1;
        if (wr_allow) n_writes++;
        chk("wr_allow", 68'(wr_allow), 68'(e_wr));
        if (e_wr) begin
            chk("wr_addr", 68'(wr_addr), 68'(e_addr));
            chk("wr_data", wr_data, e_data);
        end
        chk("commit_addr", 68'(wr_commit_addr), 68'(m_commit));
        chk("commit_toggle", 68'(wr_commit_toggle), 68'(m_toggle));
        chk("frames_dropped", 68'(frames_dropped), 68'(m_dropped % 65536));
        chk("overflow_pulse", 68'(overflow_pulse), 68'(e_ovf));
        chk("fifo_full", 68'(fifo_full), 68'(e_full));
        rx_axis_tvalid = 0;
    endtask

    task automatic do_reset();
        @(negedge wr_clk);
        wr_sreset = 1; rx_axis_tvalid = 0;
        @(posedge wr_clk);
        #1;
        chk("rst_wr_allow", 68'(wr_allow), 68'd0);
        chk("rst_wr_addr", 68'(wr_addr), 68'd0);
        chk("rst_wr_data", wr_data, 68'd0);
        chk("rst_commit", 68'(wr_commit_addr), 68'd0);
        chk("rst_toggle", 68'(wr_commit_toggle), 68'd0);
        chk("rst_full", 68'(fifo_full), 68'd0);
        chk("rst_dropped", 68'(frames_dropped), 68'd0);
        chk("rst_ovf", 68'(overflow_pulse), 68'd0);
        model_reset();
        wr_sreset = 0;
    endtask

    task automatic frame(input int len, input bit u, input logic [7:0] last_keep);
        for (int b = 0; b < len; b++) begin
            step(1, {$urandom, $urandom}, (b == len - 1) ? last_keep : 8'hFF, b == len - 1, u);
        end
    endtask

    initial begin
        wr_sreset = 1; rx_axis_tvalid = 0; rx_axis_tdata = '0; rx_axis_tkeep = 8'hFF;
        rx_axis_tlast = 0; rx_axis_tuser = 0; rd_addr_sync = '0;
        kv[0] = '{8'hFF, 3'd0}; kv[1] = '{8'h01, 3'd1}; kv[2] = '{8'h03, 3'd2};
        kv[3] = '{8'h07, 3'd3}; kv[4] = '{8'h0F, 3'd4}; kv[5] = '{8'h1F, 3'd5};
        kv[6] = '{8'h3F, 3'd6}; kv[7] = '{8'h7F, 3'd7};
        repeat (2) @(posedge wr_clk);
        do_reset();

        // Keep code table, one single-beat good frame per entry.
        for (int i = 0; i < 8; i++) begin
            step(1, 64'hA5A5_0000_0000_0000 | 64'(i), kv[i].keep, 1, 1);
            chk("keep_code", 68'(wr_data[66:64]), 68'(kv[i].code));
        end

        // 3-beat good frame from reset.
        do_reset();
        frame(3, 1, 8'h0F);
        chk("f1_addr", 68'(wr_addr), 68'd2);
        chk("f1_last", 68'(wr_data[67]), 68'd1);
        chk("f1_code", 68'(wr_data[66:64]), 68'd4);
        chk("f1_commit", 68'(wr_commit_addr), 68'd3);
        chk("f1_toggle", 68'(wr_commit_toggle), 68'd1);

        // Bad frame rolled back; next good frame reuses address 0.
        do_reset();
        frame(2, 0, 8'hFF);
        frame(1, 1, 8'h01);
        chk("bad_addr", 68'(wr_addr), 68'd0);
        chk("bad_commit", 68'(wr_commit_addr), 68'd1);
        chk("bad_dropped", 68'(frames_dropped), 68'd1);

        // Overflow: 20-beat frame into an empty 16-deep FIFO.
        do_reset();
        n_writes = 0;
        frame(20, 1, 8'hFF);
        chk("ovf_writes", 68'(n_writes), 68'd15);
        chk("ovf_commit", 68'(wr_commit_addr), 68'd0);
        chk("ovf_dropped", 68'(frames_dropped), 68'd1);

        // Wrap: commit=ptr=14, reader at 10, 4-beat frame.
        do_reset();
        frame(14, 1, 8'hFF);
        chk("wrap_pre", 68'(wr_commit_addr), 68'd14);
        rd_addr_sync = 4'd10;
        frame(4, 1, 8'hFF);
        chk("wrap_addr", 68'(wr_addr), 68'd1);
        chk("wrap_commit", 68'(wr_commit_addr), 68'd2);

        // Reset mid-frame, then a fresh frame from address 0.
        rd_addr_sync = '0;
        do_reset();
        step(1, 64'h1, 8'hFF, 0, 0);
        step(1, 64'h2, 8'hFF, 0, 0);
        do_reset();
        frame(2, 1, 8'h03);
        chk("rst_mid_commit", 68'(wr_commit_addr), 68'd2);
        chk("rst_mid_dropped", 68'(frames_dropped), 68'd0);

        // Full on a single-beat frame, then space frees up.
        do_reset();
        frame(15, 1, 8'hFF);
        frame(1, 1, 8'hFF);
        chk("full1_ovf", 68'(overflow_pulse), 68'd1);
        chk("full1_allow", 68'(wr_allow), 68'd0);
        rd_addr_sync = 4'd5;
        frame(1, 1, 8'h07);
        chk("full1_addr", 68'(wr_addr), 68'd15);
        chk("full1_commit", 68'(wr_commit_addr), 68'd0);

        // Randomized traffic against the model.
        for (int f = 0; f < 300; f++) begin
            int len;
            len = $urandom_range(1, 8);
            if ($urandom_range(0, 3) == 0) rd_addr_sync = 4'($urandom_range(0, DEPTH - 1));
            for (int b = 0; b < len; b++) begin
                if ($urandom_range(0, 4) == 0) step(0, '0, 8'hFF, 0, 0);
                step(1, {$urandom, $urandom},
                     (b == len - 1) ? kv[$urandom_range(0, 7)].keep : 8'hFF,
                     b == len - 1, $urandom_range(0, 3) != 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
